// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: moves LANES words between a single-port word memory and
// a LANES*DW vector register. A load walks LANES addresses, captures the data
// that arrives one cycle later, and publishes the full vector on completion.
// A store walks LANES addresses with the write strobe high.
//
// Optional feature macro: VMS_STRIDE_EN
//   defined   -> adds input port 'stride' (AW bits), latched on acceptance
//   undefined -> no stride port, lane addresses are consecutive (stride 1)
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting; a request is accepted here (store wins over load)
// READ   | LANES cycles driving load addresses, capturing lanes 0..LANES-2
// DRAIN  | one cycle capturing the last lane, rvec loaded on exit
// WRITE  | LANES cycles driving store address/data with mem_we high
// DONE   | one-cycle completion pulse, then back to IDLE
module vec_mem_sequencer #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int AW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic [AW-1:0]       base_addr,
    input  logic [LANES*DW-1:0] wvec,
    input  logic [DW-1:0]       mem_rdata,
`ifdef VMS_STRIDE_EN
    input  logic [AW-1:0]       stride,
`endif
    output logic [AW-1:0]       mem_addr,
    output logic                mem_we,
    output logic [DW-1:0]       mem_wdata,
    output logic [LANES*DW-1:0] rvec,
    output logic                stall,
    output logic                done,
    output logic                err
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       idx_q;
    logic [AW-1:0]       stride_q;
    logic [LANES*DW-1:0] wdat_q;
    logic [LANES*DW-1:0] cap_q;
    logic [LANES*DW-1:0] cap_d;
    logic [LANES*DW-1:0] rvec_q;
    logic [AW-1:0]       mem_addr_q;
    logic                mem_we_q;
    logic [DW-1:0]       mem_wdata_q;
    logic                done_q;
    logic                err_q;
    logic [DW-1:0]       wlane_d;
    logic [AW-1:0]       stride_in;

`ifdef VMS_STRIDE_EN
    assign stride_in = stride;
`else
    assign stride_in = AW'(1);
`endif

    // Next store lane: the latched lane following the one currently on the bus.
    always_comb begin
        wlane_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i == int'(idx_q) + 1) begin
                wlane_d = wdat_q[i*DW +: DW];
            end
        end
    end

    // Capture update: READ cycle k (k>=1) holds data for lane k-1, DRAIN holds the last lane.
    always_comb begin
        cap_d = cap_q;
        if (state_q == S_READ) begin
            for (int i = 0; i < LANES; i++) begin
                if (i + 1 == int'(idx_q)) begin
                    cap_d[i*DW +: DW] = mem_rdata;
                end
            end
        end
        if (state_q == S_DRAIN) begin
            cap_d[(LANES-1)*DW +: DW] = mem_rdata;
        end
    end

    // Sequencer FSM with registered memory-side and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            stride_q    <= '0;
            wdat_q      <= '0;
            cap_q       <= '0;
            rvec_q      <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cap_q  <= cap_d;
            case (state_q)
                S_IDLE: begin
                    if (wr_req) begin
                        state_q     <= S_WRITE;
                        idx_q       <= '0;
                        stride_q    <= stride_in;
                        wdat_q      <= wvec;
                        mem_addr_q  <= base_addr;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= wvec[DW-1:0];
                        // a simultaneous load is dropped and flagged
                        err_q       <= rd_req;
                    end else if (rd_req) begin
                        state_q    <= S_READ;
                        idx_q      <= '0;
                        stride_q   <= stride_in;
                        mem_addr_q <= base_addr;
                    end
                end
                S_READ: begin
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == LAST) begin
                        state_q    <= S_DRAIN;
                        mem_addr_q <= '0;
                    end else begin
                        mem_addr_q <= mem_addr_q + stride_q;
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                    rvec_q  <= cap_d;
                    done_q  <= 1'b1;
                end
                S_WRITE: begin
                    if (idx_q == LAST) begin
                        state_q     <= S_DONE;
                        idx_q       <= '0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        done_q      <= 1'b1;
                    end else begin
                        idx_q       <= idx_q + IW'(1);
                        mem_addr_q  <= mem_addr_q + stride_q;
                        mem_wdata_q <= wlane_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Front-end freeze: asserted as soon as a request is seen in IDLE, released in DONE.
    always_comb begin
        stall = ((state_q == S_IDLE) && (rd_req || wr_req)) ||
                (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign rvec      = rvec_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_vec_mem_sequencer;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int VW    = LANES * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic          wr_req;
    logic [AW-1:0] base_addr;
    logic [VW-1:0] wvec;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [VW-1:0] rvec;
    logic          stall;
    logic          done;
    logic          err;
`ifdef VMS_STRIDE_EN
    logic [AW-1:0] stride;
`endif

    vec_mem_sequencer #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .base_addr (base_addr),
        .wvec      (wvec),
        .mem_rdata (mem_rdata),
`ifdef VMS_STRIDE_EN
        .stride    (stride),
`endif
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .rvec      (rvec),
        .stall     (stall),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // Memory seen by the DUT: synchronous read, data one cycle after address.
    logic [DW-1:0] bmem [int];
    always @(posedge clk) begin
        if (mem_we === 1'b1) bmem[int'(mem_addr)] = mem_wdata;
        mem_rdata <= bmem.exists(int'(mem_addr)) ? bmem[int'(mem_addr)] : init_word(mem_addr);
    end

    // Model memory, updated only from the model's own expected stores.
    logic [DW-1:0] mmem [int];
    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return mmem.exists(int'(a)) ? mmem[int'(a)] : init_word(a);
    endfunction

    // Transaction model: kind 0 idle, 1 load, 2 store; t = accepting cycle.
    int            m_kind = 0;
    int            m_t    = 0;
    logic [AW-1:0] m_base;
    logic [AW-1:0] m_stride;
    logic [VW-1:0] m_data;
    logic [VW-1:0] m_load;
    logic [VW-1:0] m_rvec = '0;
    logic          m_err;

    initial begin : model_cmp
        int k;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic ewe, edone, eerr, estall, chk_a, chk_d;
        forever begin
            @(negedge clk);
            if (!started) continue;
            k      = cyc - m_t;
            ewe    = 1'b0;
            edone  = 1'b0;
            eerr   = 1'b0;
            ea     = '0;
            ed     = '0;
            chk_a  = 1'b1;
            chk_d  = 1'b1;
            estall = (m_kind == 0) && (rd_req || wr_req);
            if (m_kind == 1) begin
                if (k <= LANES) begin
                    estall = 1'b1;
                    ea     = m_base + AW'(k - 1) * m_stride;
                    chk_d  = 1'b0;
                end else if (k == LANES + 1) begin
                    estall = 1'b1;
                    chk_a  = 1'b0;
                    chk_d  = 1'b0;
                end else begin
                    edone  = 1'b1;
                    chk_a  = 1'b0;
                    chk_d  = 1'b0;
                    m_rvec = m_load;
                end
            end else if (m_kind == 2) begin
                if (k <= LANES) begin
                    estall = 1'b1;
                    ewe    = 1'b1;
                    ea     = m_base + AW'(k - 1) * m_stride;
                    ed     = m_data[(k-1)*DW +: DW];
                    mmem[int'(ea)] = ed;
                end else begin
                    edone = 1'b1;
                    chk_a = 1'b0;
                    chk_d = 1'b0;
                end
                eerr = m_err && (k == 1);
            end
            check("mem_we", VW'(mem_we), VW'(ewe));
            check("done", VW'(done), VW'(edone));
            check("err", VW'(err), VW'(eerr));
            check("stall", VW'(stall), VW'(estall));
            check("rvec", rvec, m_rvec);
            if (chk_a) check("mem_addr", VW'(mem_addr), VW'(ea));
            if (chk_d) check("mem_wdata", VW'(mem_wdata), VW'(ed));

            if (rst) begin
                m_kind = 0;
                m_rvec = '0;
            end else if (m_kind == 0) begin
                if (wr_req || rd_req) begin
                    m_t    = cyc;
                    m_base = base_addr;
`ifdef VMS_STRIDE_EN
                    m_stride = stride;
`else
                    m_stride = AW'(1);
`endif
                    m_err  = rd_req && wr_req;
                    m_data = wvec;
                    m_kind = wr_req ? 2 : 1;
                    if (m_kind == 1)
                        for (int i = 0; i < LANES; i++)
                            m_load[i*DW +: DW] = model_rd(m_base + AW'(i) * m_stride);
                end
            end else if ((m_kind == 1 && k == LANES + 2) || (m_kind == 2 && k == LANES + 1)) begin
                m_kind = 0;
            end
        end
    end

    // Per-cycle observations of one directed operation, index = cycles after acceptance.
    logic [AW-1:0] obs_addr  [1:10];
    logic [DW-1:0] obs_wdata [1:10];
    logic          obs_we    [1:10];
    logic          obs_done  [1:10];
    logic          obs_err   [1:10];
    logic          obs_stall [1:10];

    task automatic run_op(input logic rd, input logic wr, input logic [AW-1:0] base,
                          input logic [VW-1:0] data, input int rst_at);
        @(posedge clk); #1;
        rst = 1'b0; rd_req = rd; wr_req = wr; base_addr = base; wvec = data;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            rd_req = 1'b0; wr_req = 1'b0; rst = (k == rst_at);
            @(negedge clk);
            obs_addr[k]  = mem_addr;
            obs_wdata[k] = mem_wdata;
            obs_we[k]    = mem_we;
            obs_done[k]  = done;
            obs_err[k]   = err;
            obs_stall[k] = stall;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    localparam logic [VW-1:0] LOAD_VEC  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [VW-1:0] STORE_VEC = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;

    initial begin : stim
        int r;
        int ndone;
        logic [DW-1:0] lane_v;
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; base_addr = '0; wvec = '0;
`ifdef VMS_STRIDE_EN
        stride = 16'd1;
`endif
        repeat (2) @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        check("reset mem_we", VW'(mem_we), VW'(0));
        check("reset done", VW'(done), VW'(0));
        check("reset err", VW'(err), VW'(0));
        check("reset rvec", rvec, VW'(0));
        check("reset mem_addr", VW'(mem_addr), VW'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Load from 0x10 with known contents.
        for (int i = 0; i < 4; i++) begin
            lane_v = LOAD_VEC[i*DW +: DW];
            bmem[16 + i] = lane_v;
            mmem[16 + i] = lane_v;
        end
        run_op(1'b1, 1'b0, 16'h0010, '0, 0);
        for (int k = 1; k <= 4; k++) begin
            check("load addr", VW'(obs_addr[k]), VW'(16'h000F + k));
            check("load we", VW'(obs_we[k]), VW'(0));
        end
        check("load done t+5", VW'(obs_done[5]), VW'(0));
        check("load done t+6", VW'(obs_done[6]), VW'(1));
        check("load rvec", rvec, LOAD_VEC);

        // Store to 0x20.
        run_op(1'b0, 1'b1, 16'h0020, STORE_VEC, 0);
        for (int k = 1; k <= 4; k++) begin
            check("store we", VW'(obs_we[k]), VW'(1));
            check("store addr", VW'(obs_addr[k]), VW'(16'h001F + k));
            check("store data", VW'(obs_wdata[k]), VW'({4{8'hA0 + 8'(k - 1)}}));
        end
        check("store we t+5", VW'(obs_we[5]), VW'(0));
        check("store done t+5", VW'(obs_done[5]), VW'(1));
        check("store rvec kept", rvec, LOAD_VEC);
        check("store mem 0x22", VW'(bmem[32'h22]), VW'(32'hA2A2A2A2));

        // Conflict: store wins, err at t+1.
        run_op(1'b1, 1'b1, 16'h0030, {32'h0D, 32'h0C, 32'h0B, 32'h0A}, 0);
        check("conflict err t+1", VW'(obs_err[1]), VW'(1));
        check("conflict err t+2", VW'(obs_err[2]), VW'(0));
        check("conflict we", VW'(obs_we[1]), VW'(1));
        check("conflict addr t+4", VW'(obs_addr[4]), VW'(16'h0033));
        check("conflict done t+5", VW'(obs_done[5]), VW'(1));
        check("conflict rvec kept", rvec, LOAD_VEC);

        // Wrap-around load.
        run_op(1'b1, 1'b0, 16'hFFFE, '0, 0);
        check("wrap addr0", VW'(obs_addr[1]), VW'(16'hFFFE));
        check("wrap addr1", VW'(obs_addr[2]), VW'(16'hFFFF));
        check("wrap addr2", VW'(obs_addr[3]), VW'(16'h0000));
        check("wrap addr3", VW'(obs_addr[4]), VW'(16'h0001));

        // Reset in the middle of a store.
        run_op(1'b0, 1'b1, 16'h0040, STORE_VEC, 2);
        check("rst we t+2", VW'(obs_we[2]), VW'(1));
        check("rst we t+3", VW'(obs_we[3]), VW'(0));
        check("rst stall t+3", VW'(obs_stall[3]), VW'(0));
        ndone = 0;
        for (int k = 1; k <= 10; k++) ndone += int'(obs_done[k]);
        check("rst no done", VW'(ndone), VW'(0));
        check("rst rvec", rvec, VW'(0));

`ifdef VMS_STRIDE_EN
        stride = 16'd4;
        run_op(1'b1, 1'b0, 16'h0100, '0, 0);
        check("stride addr0", VW'(obs_addr[1]), VW'(16'h0100));
        check("stride addr1", VW'(obs_addr[2]), VW'(16'h0104));
        check("stride addr2", VW'(obs_addr[3]), VW'(16'h0108));
        check("stride addr3", VW'(obs_addr[4]), VW'(16'h010C));
`endif

        // Randomized traffic, including requests while busy and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 249) == 0);
            r = $urandom_range(0, 9);
            rd_req = (r < 3) || (r == 9);
            wr_req = (r == 3) || (r == 4) || (r == 9);
            if ($urandom_range(0, 3) == 0) base_addr = 16'hFFFC + AW'($urandom_range(0, 3));
            else base_addr = AW'($urandom);
            wvec = {$urandom, $urandom, $urandom, $urandom};
`ifdef VMS_STRIDE_EN
            stride = AW'($urandom_range(0, 2) == 0 ? $urandom : $urandom_range(0, 8));
`endif
        end
        @(posedge clk); #1;
        rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
